led_scanner: RTL and testbench

- Scan engine for the 64x64 HUB75 panel: the driving end of the painter interface.
- Generates the pixel coordinates and the frame/subframe counters that painters consume.
- Samples the 3-bit rgb a painter returns DELAY cycles later, pairs top and bottom half pixels, and drives the panel shift clock, latch, output enable and row address.

---
 rtl/led_scanner.sv | 164 ++++++++++++++++
 tb/tb_led_scanner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_scanner.sv
// HUB75 scan engine for a 64x64 panel: issues pixel coordinates to a painter,
// pairs the top/bottom responses and drives shift clock, latch, OE and row address.
module led_scanner #(
   parameter int FRAME_BITS = 7,
   parameter int DELAY      = 3
) (
   input  logic                  clk,
   input  logic                  resetn,
   output logic [5:0]            x,
   output logic [5:0]            y,
   output logic [FRAME_BITS-1:0] frame,
   output logic [7:0]            subframe,
   input  logic [2:0]            rgb,
   output logic [2:0]            panel_rgb0,
   output logic [2:0]            panel_rgb1,
   output logic [4:0]            panel_addr,
   output logic                  panel_clk,
   output logic                  panel_lat,
   output logic                  panel_oe
);

   typedef enum logic [1:0] {SHIFT, DRAIN, BLANK, LATCH} state_t;

   localparam logic [7:0] LAST_Q    = 8'd127;
   localparam logic [7:0] DRAIN_END = 8'(129 + DELAY);

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [4:0]            row_q, row_d;
   logic [5:0]            x_q, x_d, y_q, y_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [7:0]            subframe_q, subframe_d;
   logic [DELAY-1:0]      vld_q, vld_d, bot_q, bot_d;
   logic [2:0]            top_q, top_d, rgb0_q, rgb0_d, rgb1_q, rgb1_d;
   logic                  strobe_q, strobe_d;
   logic                  pclk_q, pclk_d, lat_q, lat_d, oe_q, oe_d;
   logic [4:0]            addr_q, addr_d;
   logic [6:0]            next_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 8'd1;
      row_d      = row_q;
      x_d        = x_q;
      y_d        = y_q;
      frame_d    = frame_q;
      subframe_d = subframe_q;
      top_d      = top_q;
      rgb0_d     = rgb0_q;
      rgb1_d     = rgb1_q;
      strobe_d   = 1'b0;
      addr_d     = addr_q;
      oe_d       = oe_q;
      vld_d      = '0;
      bot_d      = '0;
      next_q     = cnt_q[6:0] + 7'd1;

      case (state_q)
         SHIFT: begin
            if (cnt_q == LAST_Q) begin
               state_d = DRAIN;
            end else begin
               x_d = next_q[6:1];
               y_d = {next_q[0], row_q};
            end
         end
         DRAIN: begin
            if (cnt_q == DRAIN_END) state_d = BLANK;
         end
         BLANK: begin
            state_d = LATCH;
         end
         LATCH: begin
            state_d = SHIFT;
            cnt_d   = 8'd0;
            row_d   = row_q + 5'd1;
            if (row_q == 5'd31) begin
               subframe_d = subframe_q + 8'd1;
               if (subframe_q == 8'd255) frame_d = frame_q + FRAME_BITS'(1);
            end
            x_d = 6'd0;
            y_d = {1'b0, row_d};
         end
         default: state_d = SHIFT;
      endcase

      // Each query launches a {valid, bottom} token that lands when its rgb is due.
      vld_d[0] = (state_q == SHIFT);
      bot_d[0] = cnt_q[0];
      for (int i = 1; i < DELAY; i++) begin
         vld_d[i] = vld_q[i-1];
         bot_d[i] = bot_q[i-1];
      end

      if (vld_q[DELAY-1]) begin
         if (bot_q[DELAY-1]) begin
            rgb0_d   = top_q;
            rgb1_d   = rgb;
            strobe_d = 1'b1;
         end else begin
            top_d = rgb;
         end
      end

      // Shift clock trails the data by one cycle so its rising edge sits mid-hold.
      pclk_d = strobe_q;
      lat_d  = (state_d == LATCH);
      if (state_d == LATCH) addr_d = row_q;
      if (state_d == BLANK) oe_d = 1'b1;
      else if (state_q == LATCH) oe_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= SHIFT;
         cnt_q      <= 8'd0;
         row_q      <= 5'd0;
         x_q        <= 6'd0;
         y_q        <= 6'd0;
         frame_q    <= '0;
         subframe_q <= 8'd0;
         vld_q      <= '0;
         bot_q      <= '0;
         top_q      <= 3'd0;
         rgb0_q     <= 3'd0;
         rgb1_q     <= 3'd0;
         strobe_q   <= 1'b0;
         pclk_q     <= 1'b0;
         lat_q      <= 1'b0;
         oe_q       <= 1'b1;
         addr_q     <= 5'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         row_q      <= row_d;
         x_q        <= x_d;
         y_q        <= y_d;
         frame_q    <= frame_d;
         subframe_q <= subframe_d;
         vld_q      <= vld_d;
         bot_q      <= bot_d;
         top_q      <= top_d;
         rgb0_q     <= rgb0_d;
         rgb1_q     <= rgb1_d;
         strobe_q   <= strobe_d;
         pclk_q     <= pclk_d;
         lat_q      <= lat_d;
         oe_q       <= oe_d;
         addr_q     <= addr_d;
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign frame      = frame_q;
   assign subframe   = subframe_q;
   assign panel_rgb0 = rgb0_q;
   assign panel_rgb1 = rgb1_q;
   assign panel_addr = addr_q;
   assign panel_clk  = pclk_q;
   assign panel_lat  = lat_q;
   assign panel_oe   = oe_q;

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner: one instance with DELAY=3 and one with DELAY=1,
// each fed by a painter model returning {x[0], y[5], 1} after its latency.
module tb_led_scanner;

   localparam int FB = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetnA, resetnB;
   logic [2:0]    rgbA, rgbB;
   logic [5:0]    xA, yA, xB, yB;
   logic [FB-1:0] frameA, frameB;
   logic [7:0]    subA, subB;
   logic [2:0]    rgb0A, rgb1A, rgb0B, rgb1B;
   logic [4:0]    addrA, addrB;
   logic          pclkA, latA, oeA, pclkB, latB, oeB;

   led_scanner #(.FRAME_BITS(FB), .DELAY(3)) dut_a (
      .clk(clk), .resetn(resetnA), .x(xA), .y(yA), .frame(frameA), .subframe(subA),
      .rgb(rgbA), .panel_rgb0(rgb0A), .panel_rgb1(rgb1A), .panel_addr(addrA),
      .panel_clk(pclkA), .panel_lat(latA), .panel_oe(oeA));

   led_scanner #(.FRAME_BITS(FB), .DELAY(1)) dut_b (
      .clk(clk), .resetn(resetnB), .x(xB), .y(yB), .frame(frameB), .subframe(subB),
      .rgb(rgbB), .panel_rgb0(rgb0B), .panel_rgb1(rgb1B), .panel_addr(addrB),
      .panel_clk(pclkB), .panel_lat(latB), .panel_oe(oeB));

   // Painter models: a plain delay line of the colour computed from each issued coordinate.
   logic [2:0] histA [0:2];
   logic [2:0] histB;
   always @(posedge clk) begin
      histA[0] <= {xA[0], yA[5], 1'b1};
      histA[1] <= histA[0];
      histA[2] <= histA[1];
      histB    <= {xB[0], yB[5], 1'b1};
   end
   assign rgbA = histA[2];
   assign rgbB = histB;

   logic          sel = 1'b0;
   logic [5:0]    obX, obY;
   logic [FB-1:0] obFrame;
   logic [7:0]    obSub;
   logic [2:0]    obRgb0, obRgb1;
   logic [4:0]    obAddr;
   logic          obClk, obLat, obOe;
   assign obX     = sel ? xB : xA;
   assign obY     = sel ? yB : yA;
   assign obFrame = sel ? frameB : frameA;
   assign obSub   = sel ? subB : subA;
   assign obRgb0  = sel ? rgb0B : rgb0A;
   assign obRgb1  = sel ? rgb1B : rgb1A;
   assign obAddr  = sel ? addrB : addrA;
   assign obClk   = sel ? pclkB : pclkA;
   assign obLat   = sel ? latB : latA;
   assign obOe    = sel ? oeB : oeA;

   typedef struct {
      bit         dut;
      int         c;
      logic [5:0] x;
      logic [5:0] y;
      logic       pclk;
      logic       lat;
      logic       oe;
   } vec_t;

   vec_t tbl [15];
   int   testsRun = 0;
   int   testsFailed = 0;

   task automatic checkOutput(input string name, input int act, input int exp);
      testsRun++;
      if (act != exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Runs one full row of the selected instance starting at its cycle 0.
   task automatic applyStimulus(input int period, input int firstClk, input bit firstRow,
                                input int row, input int expSub, input int expFrame);
      int pulses = 0, firstP = -1, lastP = -1, latN = 0, latC = -1;
      int oeBad = 0, rgbBad = 0, overlap = 0, addrAtLat = -1;
      logic [5:0] col;
      logic       expOe;
      for (int c = 0; c < period; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checkOutput($sformatf("row%0d_start_x", row), obX, 0);
            checkOutput($sformatf("row%0d_start_y", row), obY, row);
            checkOutput($sformatf("row%0d_start_addr", row), obAddr, firstRow ? 0 : (row + 31) % 32);
            if (expSub >= 0) checkOutput($sformatf("row%0d_subframe", row), obSub, expSub);
            if (expFrame >= 0) checkOutput($sformatf("row%0d_frame", row), obFrame, expFrame);
         end
         if (firstRow) begin
            for (int i = 0; i < 15; i++) begin
               if (tbl[i].dut == sel && tbl[i].c == c) begin
                  checkOutput($sformatf("vec%0d_x", i), obX, tbl[i].x);
                  checkOutput($sformatf("vec%0d_y", i), obY, tbl[i].y);
                  checkOutput($sformatf("vec%0d_clk", i), obClk, tbl[i].pclk);
                  checkOutput($sformatf("vec%0d_lat", i), obLat, tbl[i].lat);
                  checkOutput($sformatf("vec%0d_oe", i), obOe, tbl[i].oe);
               end
            end
         end
         if (obClk) begin
            col = 6'(pulses);
            if (obRgb0 !== {col[0], 1'b0, 1'b1} || obRgb1 !== {col[0], 1'b1, 1'b1}) rgbBad++;
            if (firstP < 0) firstP = c;
            lastP = c;
            pulses++;
         end
         if (obLat) begin
            latN++;
            latC = c;
            addrAtLat = obAddr;
         end
         if (obClk && obLat) overlap++;
         expOe = firstRow ? 1'b1 : (c >= period - 2);
         if (obOe !== expOe) oeBad++;
      end
      checkOutput($sformatf("row%0d_pulses", row), pulses, 64);
      checkOutput($sformatf("row%0d_first_clk", row), firstP, firstClk);
      checkOutput($sformatf("row%0d_last_clk", row), lastP, firstClk + 126);
      checkOutput($sformatf("row%0d_lat_count", row), latN, 1);
      checkOutput($sformatf("row%0d_lat_cycle", row), latC, period - 1);
      checkOutput($sformatf("row%0d_addr_at_lat", row), addrAtLat, row);
      checkOutput($sformatf("row%0d_rgb_bad", row), rgbBad, 0);
      checkOutput($sformatf("row%0d_oe_bad", row), oeBad, 0);
      checkOutput($sformatf("row%0d_clk_lat_overlap", row), overlap, 0);
   endtask

   initial begin
      resetnA = 1'b0;
      resetnB = 1'b0;
      tbl[0]  = '{0,   0,  6'd0,  6'd0,  1'b0, 1'b0, 1'b1};
      tbl[1]  = '{0,   1,  6'd0,  6'd32, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{0,   2,  6'd1,  6'd0,  1'b0, 1'b0, 1'b1};
      tbl[3]  = '{0,   3,  6'd1,  6'd32, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{0,   5,  6'd2,  6'd32, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{0,   6,  6'd3,  6'd0,  1'b1, 1'b0, 1'b1};
      tbl[6]  = '{0,   7,  6'd3,  6'd32, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{0, 128,  6'd63, 6'd32, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{0, 133,  6'd63, 6'd32, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{0, 134,  6'd63, 6'd32, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{1,   3,  6'd1,  6'd32, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1,   4,  6'd2,  6'd0,  1'b1, 1'b0, 1'b1};
      tbl[12] = '{1, 130,  6'd63, 6'd32, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{1, 131,  6'd63, 6'd32, 1'b0, 1'b0, 1'b1};
      tbl[14] = '{1, 132,  6'd63, 6'd32, 1'b0, 1'b1, 1'b1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_x", obX, 0);
      checkOutput("reset_y", obY, 0);
      checkOutput("reset_frame", obFrame, 0);
      checkOutput("reset_subframe", obSub, 0);
      checkOutput("reset_rgb0", obRgb0, 0);
      checkOutput("reset_rgb1", obRgb1, 0);
      checkOutput("reset_addr", obAddr, 0);
      checkOutput("reset_clk", obClk, 0);
      checkOutput("reset_lat", obLat, 0);
      checkOutput("reset_oe", obOe, 1);

      @(posedge clk);
      #2 resetnA = 1'b1;
      for (int r = 0; r < 32; r++) applyStimulus(135, 6, r == 0, r, 0, 0);
      for (int r = 0; r < 31; r++) applyStimulus(135, 6, 1'b0, r, 1, 0);

      // Jump the counters to the brink of a full wrap before the last row of the subframe.
      force dut_a.subframe_q = 8'd255;
      force dut_a.frame_q = 7'd127;
      fork
         begin
            repeat (3) @(posedge clk);
            #1;
            release dut_a.subframe_q;
            release dut_a.frame_q;
         end
      join_none
      applyStimulus(135, 6, 1'b0, 31, -1, -1);
      @(negedge clk);
      checkOutput("wrap_subframe", obSub, 0);
      checkOutput("wrap_frame", obFrame, 0);
      checkOutput("wrap_y", obY, 0);

      force dut_a.frame_q = 7'd42;
      fork
         begin
            repeat (3) @(posedge clk);
            #1;
            release dut_a.frame_q;
         end
      join_none
      repeat (60) @(negedge clk);
      checkOutput("midrow_x_before", obX, 30);
      checkOutput("midrow_clk_before", obClk, 1);
      checkOutput("midrow_oe_before", obOe, 0);
      #1 resetnA = 1'b0;
      #1;
      checkOutput("midrow_oe_async", obOe, 1);
      checkOutput("midrow_clk_async", obClk, 0);
      checkOutput("midrow_lat_async", obLat, 0);
      checkOutput("midrow_x_async", obX, 0);
      @(posedge clk);
      @(posedge clk);
      #2 resetnA = 1'b1;
      applyStimulus(135, 6, 1'b1, 0, 0, 0);

      sel = 1'b1;
      @(posedge clk);
      #2 resetnB = 1'b1;
      applyStimulus(133, 4, 1'b1, 0, 0, 0);
      applyStimulus(133, 4, 1'b0, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
